// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the shared data-memory port: the CPU owns the port by default,
// the external master is granted when the CPU is idle or after a bounded wait, and holds it for a bounded time.
module dmem_arbiter #(
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [3:0]    cpu_be,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [DW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    input  logic [3:0]    ext_be,
    output logic          ext_gnt,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT) + 1;
    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    owner_t          r_owner;
    logic [WW-1:0]   r_ext_wait;
    logic [HW-1:0]   r_hold_cnt;
    logic            w_own_ext;

    assign w_own_ext = (r_owner == OWN_EXT);

    // Ownership FSM with the ext wait counter (contended cycles) and hold counter (cycles owned)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner    <= OWN_CPU;
            r_ext_wait <= WW'(0);
            r_hold_cnt <= HW'(0);
        end else begin
            case (r_owner)
                OWN_CPU: begin
                    if (ext_req && (!cpu_req || (r_ext_wait == WAIT_LAST))) begin
                        r_owner    <= OWN_EXT;
                        r_ext_wait <= WW'(0);
                        r_hold_cnt <= HW'(0);
                    end else if (ext_req) begin
                        // Both requesting and the wait bound not yet reached
                        r_ext_wait <= r_ext_wait + WW'(1);
                    end else begin
                        r_ext_wait <= WW'(0);
                    end
                end
                OWN_EXT: begin
                    if (!ext_req || (cpu_req && (r_hold_cnt == HOLD_LAST))) begin
                        r_owner    <= OWN_CPU;
                        r_hold_cnt <= HW'(0);
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end else begin
                        r_hold_cnt <= r_hold_cnt;
                    end
                end
                default: begin
                    r_owner    <= OWN_CPU;
                    r_ext_wait <= WW'(0);
                    r_hold_cnt <= HW'(0);
                end
            endcase
        end
    end

    // Port mux follows the current owner; a write needs the owner's request as well as its we
    always_comb begin
        if (w_own_ext) begin
            mem_we    = ext_we & ext_req;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_be    = ext_be;
        end else begin
            mem_we    = cpu_we & cpu_req;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_be    = cpu_be;
        end
    end

    assign cpu_stall = cpu_req & w_own_ext;
    assign ext_gnt   = ext_req & w_own_ext;
    assign cpu_rdata = mem_rdata;
    assign ext_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked against an
// ownership/latency model and a reference copy of the data memory.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int MW = 4;
    localparam int MH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, ext_req, ext_we;
    logic [DW-1:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic [3:0]    cpu_be, ext_be;
    logic          cpu_stall, ext_gnt, mem_we;
    logic [DW-1:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]    mem_be;

    logic          tb_clear;
    logic [31:0]   dmem_arr [0:255];
    logic [31:0]   ref_mem  [0:255];

    int m_owner;
    int m_wait;
    int m_hold;
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DW(DW), .MAX_WAIT(MW), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_be(ext_be), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory behind the arbiter: combinational read, byte-enabled write at the edge
    assign mem_rdata = dmem_arr[mem_addr[9:2]];
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 256; i++) dmem_arr[i] <= 32'h0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) dmem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_wait  = 0;
        m_hold  = 0;
    endtask

    // Compare every output against what the current owner implies
    task automatic check_all();
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        e_we    = (m_owner == 1) ? (ext_we & ext_req) : (cpu_we & cpu_req);
        e_addr  = (m_owner == 1) ? ext_addr  : cpu_addr;
        e_wdata = (m_owner == 1) ? ext_wdata : cpu_wdata;
        e_be    = (m_owner == 1) ? ext_be    : cpu_be;
        check("cpu_stall", {31'h0, cpu_stall}, {31'h0, cpu_req && (m_owner == 1)});
        check("ext_gnt",   {31'h0, ext_gnt},   {31'h0, ext_req && (m_owner == 1)});
        check("mem_we",    {31'h0, mem_we},    {31'h0, e_we});
        check("mem_addr",  mem_addr,  e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_be",    {28'h0, mem_be}, {28'h0, e_be});
        check("cpu_rdata", cpu_rdata, ref_mem[e_addr[9:2]]);
        check("ext_rdata", ext_rdata, ref_mem[e_addr[9:2]]);
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    // Advance one edge: commit the expected write, then apply the ownership rules
    task automatic tick();
        logic        e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        @(posedge clk);
        e_we    = (m_owner == 1) ? (ext_we & ext_req) : (cpu_we & cpu_req);
        e_addr  = (m_owner == 1) ? ext_addr  : cpu_addr;
        e_wdata = (m_owner == 1) ? ext_wdata : cpu_wdata;
        e_be    = (m_owner == 1) ? ext_be    : cpu_be;
        if (e_we && !tb_clear)
            for (int b = 0; b < 4; b++)
                if (e_be[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_wdata[8*b +: 8];
        if (!reset) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (ext_req && (!cpu_req || m_wait >= MW - 1)) begin
                m_owner = 1;
                m_wait  = 0;
                m_hold  = 0;
            end else if (ext_req) begin
                m_wait++;
            end else begin
                m_wait = 0;
            end
        end else begin
            if (!ext_req || (cpu_req && m_hold >= MH - 1)) m_owner = 0;
            else m_hold++;
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        model_reset();
        tb_clear = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0; cpu_be = 4'hF;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20; ext_wdata = 32'h0; ext_be = 4'hF;
        reset = 1'b0;

        // Reset held with ext requesting: CPU keeps the port
        #1;
        check("rst_gnt", {31'h0, ext_gnt}, 32'h0);
        check("rst_addr", mem_addr, 32'h10);
        cycle();
        tb_clear = 1'b0;
        cycle();
        reset = 1'b1;
        sample();
        check("rel_gnt0", {31'h0, ext_gnt}, 32'h0);
        tick();
        sample();
        check("rel_gnt1", {31'h0, ext_gnt}, 32'h1);
        tick();
        ext_req = 1'b0;
        tick();

        // CPU store then load
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; cpu_be = 4'b1111;
        sample();
        check("st_we", {31'h0, mem_we}, 32'h1);
        check("st_stall", {31'h0, cpu_stall}, 32'h0);
        tick();
        cpu_we = 1'b0;
        sample();
        check("ld_data", cpu_rdata, 32'hDEADBEEF);
        tick();

        // Ext alone: write then read back
        cpu_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h80; ext_wdata = 32'h12345678; ext_be = 4'b0011;
        sample();
        check("ext_c0", {31'h0, ext_gnt}, 32'h0);
        tick();
        sample();
        check("ext_c1", {31'h0, ext_gnt}, 32'h1);
        check("ext_be", {28'h0, mem_be}, 32'h3);
        check("ext_addr", mem_addr, 32'h80);
        tick();
        ext_we = 1'b0;
        sample();
        check("ext_rd", ext_rdata, 32'h00005678);
        tick();
        ext_req = 1'b0;
        tick();

        // Continuous contention: CPU 0-3, ext 4-5, CPU 6-9, ext 10-11
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h80;
        for (int i = 0; i < 12; i++) begin
            sample();
            check("cont_stall", {31'h0, cpu_stall}, {31'h0, (i == 4) || (i == 5) || (i == 10) || (i == 11)});
            tick();
        end
        ext_req = 1'b0;
        tick();

        // Ext owns with CPU idle for several cycles, then drops as CPU requests
        cpu_req = 1'b0; ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h88; ext_wdata = 32'hA5A5A5A5; ext_be = 4'hF;
        for (int i = 0; i < 6; i++) cycle();
        ext_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h88;
        sample();
        check("drop_we", {31'h0, mem_we}, 32'h0);
        tick();
        sample();
        check("drop_stall", {31'h0, cpu_stall}, 32'h0);
        check("drop_rd", cpu_rdata, 32'hA5A5A5A5);
        tick();

        // Reset pulse while ext owns with a write pending
        cpu_req = 1'b0; ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h84; ext_wdata = 32'h11112222;
        cycle();
        cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h0BADF00D;
        #1;
        check("pre_rst_addr", mem_addr, 32'h84);
        reset = 1'b0;
        #1;
        model_reset();
        check("arst_addr", mem_addr, 32'h44);
        check("arst_we", {31'h0, mem_we}, 32'h1);
        check("arst_gnt", {31'h0, ext_gnt}, 32'h0);
        cycle();
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        sample();
        check("regnt0", {31'h0, ext_gnt}, 32'h0);
        tick();
        sample();
        check("regnt1", {31'h0, ext_gnt}, 32'h1);
        tick();

        // Random traffic with occasional async reset pulses
        for (int n = 0; n < 600; n++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            ext_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = $urandom_range(0, 1) == 1;
            ext_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = 32'($urandom_range(0, 31)) << 2;
            ext_addr  = 32'($urandom_range(0, 31)) << 2;
            cpu_wdata = $urandom;
            ext_wdata = $urandom;
            cpu_be    = 4'($urandom_range(0, 15));
            ext_be    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b0;
                #1;
                model_reset();
                check_all();
                reset = 1'b1;
                #1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter sharing the single data-memory port between the pipelined CPU (load/store from the MEM stage) and one external master (DMA/debug loader). It sits between `cpu`/external master and `dmem`, multiplexes address/data/byte-enables, stalls the CPU while the external master owns the port, and bounds latency for both sides with wait and hold counters.

## Interface
- `DW`, 32, data/address width.
- `MAX_WAIT`, 4, max contended cycles ext waits before it is granted (≥1).
- `MAX_HOLD`, 4, max consecutive cycles ext keeps ownership while CPU is requesting (≥1).

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU memory access this cycle.
- `cpu_we`  in  1  CPU store.
- `cpu_addr`, `cpu_wdata`  in  DW  CPU address / store data.
- `cpu_be`  in  4  CPU byte enables.
- `cpu_stall`  out  1  CPU access not served this cycle.
- `cpu_rdata`  out  DW  load data (= `mem_rdata`).
- `ext_req`, `ext_we`  in  1  ext access / ext write.
- `ext_addr`, `ext_wdata`  in  DW  ext address / write data.
- `ext_be`  in  4  ext byte enables.
- `ext_gnt`  out  1  ext access served this cycle.
- `ext_rdata`  out  DW  read data (= `mem_rdata`).
- `mem_we`  out  1  to `dmem` write enable.
- `mem_addr`, `mem_wdata`  out  DW  to `dmem`.
- `mem_be`  out  4  to `dmem` byte enables.
- `mem_rdata`  in  DW  from `dmem` (combinational read).

## Operation
- State: `owner` ∈ {OWN_CPU, OWN_EXT}; `ext_wait` and `hold_cnt` counters, width $clog2(max)+1, saturating.
- Mux (combinational from `owner`): OWN_CPU → `mem_*` driven from `cpu_*`; OWN_EXT → from `ext_*`.
- `mem_we` = owner's `we` AND owner's `req`; never asserted for a non-owner or idle owner.
- `cpu_stall` = `cpu_req` & (owner==OWN_EXT). `ext_gnt` = `ext_req` & (owner==OWN_EXT).
- OWN_CPU:
  - `ext_wait` increments each cycle with `ext_req`&`cpu_req`; cleared when `ext_req`=0 or on leaving state.
  - → OWN_EXT at edge if `ext_req` & (!`cpu_req` | `ext_wait`==MAX_WAIT-1).
- OWN_EXT:
  - `hold_cnt` cleared on entry, increments each cycle in state, saturates at MAX_HOLD-1.
  - → OWN_CPU at edge if !`ext_req` | (`cpu_req` & `hold_cnt`==MAX_HOLD-1).
  - With `cpu_req`=0, ext keeps ownership indefinitely.
- Switches take effect the cycle after the deciding edge; no dead cycle; new owner is served immediately.
- Stores are one cycle: write commits at the edge ending the served cycle.

## Timing
- Reset (asynchronous, `reset`=0): owner=OWN_CPU, `ext_wait`=0, `hold_cnt`=0; outputs immediately reflect OWN_CPU: `cpu_stall`=0, `ext_gnt`=0, `mem_*` follow `cpu_*`.
- Reset mid-ext-write: `mem_we` follows `cpu_we`&`cpu_req` asynchronously; the ext write is dropped and ext must re-request.
- CPU latency uncontended: 0 cycles (same-cycle service). Ext latency with CPU idle: 1 cycle. Worst-case ext latency: MAX_WAIT cycles. Worst-case CPU stall: MAX_HOLD cycles.
- Simultaneous `cpu_req` and `ext_req` arriving in OWN_CPU: CPU served first.
- Read data is valid in the same cycle as the grant (`!cpu_stall` or `ext_gnt`).

## Test plan
- Reset: hold `reset`=0 with `ext_req`=1 → `ext_gnt`=0, `cpu_stall`=0, `mem_addr`=`cpu_addr`; release, ext idle-CPU → `ext_gnt`=1 one cycle later.
- CPU only: store addr 0x40, data 0xDEADBEEF, be 4'b1111 → `mem_we`=1 same cycle, `cpu_stall`=0; following load of 0x40 returns 0xDEADBEEF.
- Ext alone: `ext_req` from cycle 0, ext write addr 0x80 data 0x12345678 be 4'b0011 → `ext_gnt`=0 at cycle 0, 1 from cycle 1, `mem_be`=4'b0011, `mem_addr`=0x80.
- Contention (MAX_WAIT=4, MAX_HOLD=2), both requesting continuously from cycle 0 → CPU served 0–3, ext 4–5, CPU 6–9, ext 10–11; `cpu_stall`=1 exactly in 4–5 and 10–11.
- Ext drops `ext_req` at cycle 5 of ownership with `cpu_req`=1 → owner OWN_CPU from next cycle, `cpu_stall`=0, `mem_we` never driven by ext while `ext_req`=0.
- Reset pulse while OWN_EXT with ext write pending → `mem_we`/`mem_addr` switch to CPU values without a clock edge; `ext_gnt`=0 until re-granted.
